uart_tx_drain: RTL

Serial transmitter that drains the synchronous FIFO and sends each word as an asynchronous UART frame on one output line. It is the FIFO's downstream consumer: it watches the FIFO empty flag, pulses the FIFO pop, and captures the FIFO's registered read data one cycle later. It then shifts out start, data, optional parity and stop bits at a fixed clocks-per-bit rate.

---
 rtl/uart_tx_drain.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - UART frame transmitter that drains a synchronous FIFO
// Pops one word when idle, then shifts out start, data (LSB first), optional parity and stop bits.
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rts_n,
  input  logic                  i_en,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_pop,
  output logic                  o_txd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + STOP_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  // Gated by reset so the pop request stays low while reset is held.
  assign o_pop   = i_rts_n & (state_q == S_IDLE) & i_en & ~i_empty;
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE && state_q != S_FETCH) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (o_pop) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        shift_d = i_data;
        par_d   = (^i_data) ^ PAR_ODD;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        // Registered pulse: set one cycle early so it lands on the last stop cycle.
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) begin
          done_d = 1'b1;
        end
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rts_n) begin
    if (!i_rts_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_txd  = txd_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
